// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter that merges NUM_CH valid/ready sources onto one registered bus
// stage, steering each beat to the sink named by its destination field.
module shared_bus_arbiter #(
  parameter  int DATA_W = 8,
  parameter  int NUM_CH = 4,
  localparam int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        src_valid,
  input  logic [NUM_CH*DATA_W-1:0] src_data,
  input  logic [NUM_CH*ID_W-1:0]   src_dest,
  output logic [NUM_CH-1:0]        src_ready,
  output logic [NUM_CH-1:0]        dst_valid,
  output logic [DATA_W-1:0]        dst_data,
  output logic [ID_W-1:0]          dst_src,
  input  logic [NUM_CH-1:0]        dst_ready,
  output logic [NUM_CH-1:0]        bus_grant,
  output logic                     err_drop
);

  localparam int unsigned NCH = NUM_CH;

  typedef enum logic {ST_EMPTY, ST_FULL} stage_t;

  stage_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q;
  logic [ID_W-1:0]     dest_q;
  logic [ID_W-1:0]     src_q;
  logic [ID_W-1:0]     ptr_q;
  logic [NUM_CH-1:0]   grant_q;
  logic                err_q;

  logic [2*NUM_CH-1:0] req_rot;
  logic                found;
  logic [ID_W-1:0]     win;
  logic [ID_W-1:0]     win_next;
  int unsigned         sum;
  logic                pop;
  logic                load;
  logic                accept;
  logic [DATA_W-1:0]   sel_data;
  logic [ID_W-1:0]     sel_dest;
  logic                dest_ok;

  always_comb begin
    dst_valid = '0;
    for (int unsigned d = 0; d < NCH; d++) begin
      if (state_q == ST_FULL && dest_q == ID_W'(d)) dst_valid[d] = 1'b1;
    end
  end

  // Pop is taken from the addressed sink only, so load frees the stage in the same cycle.
  assign pop  = |(dst_valid & dst_ready);
  assign load = (state_q == ST_EMPTY) | pop;

  always_comb begin
    req_rot = {src_valid, src_valid} >> ptr_q;
    found   = 1'b0;
    win     = '0;
    sum     = 0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        sum   = 32'(ptr_q) + k;
        if (sum >= NCH) sum = sum - NCH;
        win   = ID_W'(sum);
      end
    end
  end

  assign accept   = load & found;
  assign win_next = (win == ID_W'(NCH - 1)) ? '0 : win + ID_W'(1);

  always_comb begin
    src_ready = '0;
    sel_data  = '0;
    sel_dest  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (win == ID_W'(i)) begin
        src_ready[i] = accept;
        sel_data     = src_data[i*DATA_W +: DATA_W];
        sel_dest     = src_dest[i*ID_W +: ID_W];
      end
    end
  end

  assign dest_ok = (32'(sel_dest) < NCH);

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = dest_ok ? ST_FULL : ST_EMPTY;
    end else if (pop) begin
      state_d = ST_EMPTY;
    end
  end

  // A beat with an out-of-range destination is consumed but never enters the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      dest_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept & ~dest_ok;
      if (accept) begin
        grant_q <= src_ready;
        ptr_q   <= win_next;
        if (dest_ok) begin
          data_q <= sel_data;
          dest_q <= sel_dest;
          src_q  <= win;
        end
      end
    end
  end

  assign dst_data  = data_q;
  assign dst_src   = src_q;
  assign bus_grant = grant_q;
  assign err_drop  = err_q;

endmodule
